hazard_stall_ctrl: RTL and testbench

//  Generates stall and flush controls consumed by PC, IF/ID and ID/EX pipeline registers.
//  - Detects load-use hazards between the ID-stage instruction and the EX-stage load.
//  - Holds the pipeline for multi-cycle FPU ops (FDIV/FSQRT) resident in EX.
//  - Flushes IF/ID and ID/EX on a taken redirect from EX.
//  - Sits beside the ID/EX register: reads its outputs, drives its stall input.

---
 rtl/hazard_stall_ctrl.sv | 89 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use, multi-cycle FPU stall and redirect flush control for the ID/EX boundary.
// Optional HAZARD_PERF_CNT_EN adds stall_cycles/flush_events counters.
module hazard_stall_ctrl #(
  parameter int REGFILE_LEN = 6,
  parameter int FPU_OP_WIDTH = 5,
  parameter int MC_LAT = 4,
  parameter logic [FPU_OP_WIDTH-1:0] FDIV_OP = 5'd3,
  parameter logic [FPU_OP_WIDTH-1:0] FSQRT_OP = 5'd4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REGFILE_LEN-1:0]  id_rs1,
  input  logic [REGFILE_LEN-1:0]  id_rs2,
  input  logic                    id_uses_rs2,
  input  logic                    ex_mem_read,
  input  logic [REGFILE_LEN-1:0]  ex_rd,
  input  logic                    ex_alu_fpu,
  input  logic [FPU_OP_WIDTH-1:0] ex_fpu_op,
  input  logic                    ex_redirect,
  output logic                    pc_stall,
  output logic                    if_id_stall,
  output logic                    id_ex_stall,
  output logic                    if_id_flush,
  output logic                    id_ex_flush,
  output logic                    mc_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             flush_events
`endif
);
  localparam int CW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  typedef enum logic [1:0] {IDLE, FPU_WAIT, FPU_DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lu, mc;
  assign lu = ex_mem_read && ex_rd != '0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
  assign mc = ex_alu_fpu && (ex_fpu_op == FDIV_OP || ex_fpu_op == FSQRT_OP);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, mc_busy} = '0;
    if (state_q == FPU_WAIT) begin
      {pc_stall, if_id_stall, id_ex_stall, mc_busy} = '1;
      state_d = (cnt_q == '0) ? FPU_DONE : FPU_WAIT;
      cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    end else begin
      state_d = IDLE;
      if (ex_redirect) begin
        {if_id_flush, id_ex_flush} = '1;
      end else if (state_q == IDLE && mc) begin
        {pc_stall, if_id_stall, id_ex_stall, mc_busy} = '1;
        cnt_d = CW'(MC_LAT - 2);
        state_d = FPU_WAIT;
      end else if (lu) begin
        {pc_stall, if_id_stall, id_ex_flush} = '1;
      end
    end
    // reset must silence outputs immediately, even with an FPU op still sitting in EX
    if (rst) {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, mc_busy} = '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d, flush_events_q, flush_events_d;
  always_comb begin
    stall_cycles_d = pc_stall ? stall_cycles_q + 32'd1 : stall_cycles_q;
    flush_events_d = if_id_flush ? flush_events_q + 32'd1 : flush_events_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_events = flush_events_q;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: vector table, hand sequences and randomized model check for hazard_stall_ctrl.
module tb_hazard_stall_ctrl;
  localparam int MC_LAT = 4;
  logic clk = 0, rst = 0;
  logic [5:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_uses_rs2 = 0, ex_mem_read = 0, ex_alu_fpu = 0, ex_redirect = 0;
  logic [4:0] ex_fpu_op = 0;
  logic pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, mc_busy;
  logic [5:0] o;
  int checks = 0, errors = 0;
  int hold = 0;
  bit done = 0;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  int m_stall = 0, m_flush = 0;
`endif
  hazard_stall_ctrl #(.MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_alu_fpu(ex_alu_fpu), .ex_fpu_op(ex_fpu_op),
    .ex_redirect(ex_redirect), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mc_busy(mc_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );
  always #5 clk = ~clk;
  assign o = {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, mc_busy};
  localparam logic [5:0] MCS = 6'b111001, LUS = 6'b110010, FL = 6'b000110, NONE = 6'b000000;
  typedef struct {
    logic [5:0] rs1, rs2, rd;
    logic u2, mr, fpu, redir;
    logic [4:0] op;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[11];
  task automatic chk(input string nm, input logic [5:0] exp);
    checks++;
    if (o !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b at %0t", nm, o, exp, $time);
    end
  endtask
  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic clr();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_uses_rs2, ex_mem_read, ex_alu_fpu, ex_redirect} = '0;
    ex_fpu_op = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #2 rst = 0;
  endtask
  function automatic logic [5:0] model_out();
    logic lu, mc;
    lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    mc = ex_alu_fpu && (ex_fpu_op == 5'd3 || ex_fpu_op == 5'd4);
    if (hold > 0) return MCS;
    if (ex_redirect) return FL;
    if (!done && mc) return MCS;
    if (lu) return LUS;
    return NONE;
  endfunction
  initial begin
    tbl[0]  = '{rs1:5,  rs2:0, rd:5,  u2:0, mr:1, fpu:0, redir:0, op:0, exp:LUS};
    tbl[1]  = '{rs1:0,  rs2:0, rd:0,  u2:0, mr:1, fpu:0, redir:0, op:0, exp:NONE};
    tbl[2]  = '{rs1:1,  rs2:7, rd:7,  u2:0, mr:1, fpu:0, redir:0, op:0, exp:NONE};
    tbl[3]  = '{rs1:1,  rs2:7, rd:7,  u2:1, mr:1, fpu:0, redir:0, op:0, exp:LUS};
    tbl[4]  = '{rs1:5,  rs2:0, rd:5,  u2:0, mr:0, fpu:0, redir:0, op:0, exp:NONE};
    tbl[5]  = '{rs1:5,  rs2:0, rd:5,  u2:0, mr:1, fpu:0, redir:1, op:0, exp:FL};
    tbl[6]  = '{rs1:2,  rs2:3, rd:9,  u2:1, mr:0, fpu:0, redir:1, op:0, exp:FL};
    tbl[7]  = '{rs1:3,  rs2:0, rd:0,  u2:1, mr:1, fpu:0, redir:0, op:0, exp:NONE};
    tbl[8]  = '{rs1:63, rs2:0, rd:63, u2:0, mr:1, fpu:0, redir:0, op:0, exp:LUS};
    tbl[9]  = '{rs1:0,  rs2:0, rd:0,  u2:0, mr:0, fpu:1, redir:0, op:2, exp:NONE};
    tbl[10] = '{rs1:0,  rs2:0, rd:0,  u2:0, mr:0, fpu:0, redir:0, op:3, exp:NONE};
    rst = 1;
    #1 chk("reset_out", NONE);
    #3 rst = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd; id_uses_rs2 = tbl[i].u2;
      ex_mem_read = tbl[i].mr; ex_alu_fpu = tbl[i].fpu; ex_redirect = tbl[i].redir; ex_fpu_op = tbl[i].op;
      #1 chk($sformatf("vec%0d", i), tbl[i].exp);
    end
    // FDIV: four stall cycles, redirect ignored mid-wait, then a quiet done cycle
    @(negedge clk); clr(); ex_alu_fpu = 1; ex_fpu_op = 5'd3;
    for (int k = 0; k < MC_LAT; k++) begin
      ex_redirect = (k == 2);
      #1 chk($sformatf("fdiv_stall%0d", k), MCS);
      @(negedge clk);
    end
    ex_redirect = 0;
    #1 chk("fdiv_done", NONE);
    @(negedge clk); ex_alu_fpu = 0;
    #1 chk("fdiv_idle", NONE);
    // FSQRT: load-use seen in done cycle, then a back-to-back op
    @(negedge clk); clr(); ex_alu_fpu = 1; ex_fpu_op = 5'd4;
    for (int k = 0; k < MC_LAT; k++) begin
      #1 chk($sformatf("fsqrt_stall%0d", k), MCS);
      @(negedge clk);
    end
    ex_mem_read = 1; ex_rd = 9; id_rs1 = 9;
    #1 chk("done_lu", LUS);
    @(negedge clk);
    for (int k = 0; k < MC_LAT; k++) begin
      #1 chk($sformatf("b2b_stall%0d", k), MCS);
      @(negedge clk);
    end
    #1 chk("b2b_done_lu", LUS);
    @(negedge clk); clr();
    #1 chk("b2b_idle", NONE);
    // reset during second FPU_WAIT cycle
    @(negedge clk); ex_alu_fpu = 1; ex_fpu_op = 5'd3;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("rst_pre%0d", k), MCS);
      if (k < 2) @(negedge clk);
    end
    #1 rst = 1;
    #1 chk("rst_mid", NONE);
    #1 rst = 0; ex_alu_fpu = 0;
    @(negedge clk);
    #1 chk("rst_after", NONE);
    @(negedge clk);
    #1 chk("rst_after2", NONE);
`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    @(negedge clk); clr(); ex_alu_fpu = 1; ex_fpu_op = 5'd3;
    repeat (MC_LAT) @(negedge clk);
    clr();
    @(negedge clk); ex_mem_read = 1; ex_rd = 5; id_rs1 = 5;
    @(negedge clk); clr(); ex_redirect = 1;
    @(negedge clk); clr();
    #1 chk32("perf_stall", stall_cycles, 32'd5);
    chk32("perf_flush", flush_events, 32'd1);
`endif
    do_reset();
    hold = 0; done = 0;
`ifdef HAZARD_PERF_CNT_EN
    m_stall = 0; m_flush = 0;
`endif
    for (int n = 0; n < 400; n++) begin
      logic [5:0] e;
      bit mc_now;
      @(negedge clk);
      id_rs1 = 6'($urandom_range(0, 3)); id_rs2 = 6'($urandom_range(0, 3)); ex_rd = 6'($urandom_range(0, 3));
      id_uses_rs2 = 1'($urandom); ex_mem_read = 1'($urandom);
      ex_alu_fpu = ($urandom_range(0, 5) == 0); ex_fpu_op = 5'($urandom_range(2, 5));
      ex_redirect = ($urandom_range(0, 5) == 0);
      #1 e = model_out();
      chk($sformatf("rand%0d", n), e);
      mc_now = ex_alu_fpu && (ex_fpu_op == 5'd3 || ex_fpu_op == 5'd4);
      @(posedge clk);
`ifdef HAZARD_PERF_CNT_EN
      m_stall += int'(e[5]); m_flush += int'(e[2]);
`endif
      if (hold > 0) begin
        hold--;
        done = (hold == 0);
      end else if (!ex_redirect && !done && mc_now) begin
        hold = MC_LAT - 1;
        done = 0;
      end else done = 0;
    end
`ifdef HAZARD_PERF_CNT_EN
    #1 chk32("rand_stall_cnt", stall_cycles, 32'(m_stall));
    chk32("rand_flush_cnt", flush_events, 32'(m_flush));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
